// File: rtl/hier_bus_reader_if.sv
// Signal bundle for hier_bus_reader: the snapshot input buses, the chunk stream and the status outputs.
// master is the driving and consuming side; slave is the reader itself.
interface hier_bus_reader_if #(
  parameter int D_W     = 900,
  parameter int CHUNK_W = 30,
  parameter int E_W     = 10,
  parameter int F_W     = 5,
  parameter int IDX_W   = 5
);
  logic [D_W-1:0]       d_in;
  logic [E_W-1:0]       e_in;
  logic [F_W-1:0]       f_in;
  logic                 start;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [CHUNK_W-1:0]   out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;
  logic [E_W+F_W-1:0]   snap_ef;
  logic [CHUNK_W-1:0]   checksum;
  logic                 done;

  modport master (
    output d_in, e_in, f_in, start, out_ready,
    input  busy, out_valid, out_data, out_idx, out_last, snap_ef, checksum, done
  );

  modport slave (
    input  d_in, e_in, f_in, start, out_ready,
    output busy, out_valid, out_data, out_idx, out_last, snap_ef, checksum, done
  );
endinterface

// File: rtl/hier_bus_reader.sv
// Snapshot the wide d bus (plus e/f side buses) and stream it out as fixed-width chunks
// with an XOR checksum. Split into capture, chunk-select and control children.
module hier_bus_reader_capture #(
  parameter int D_W = 900,
  parameter int E_W = 10,
  parameter int F_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture,
  input  logic [D_W-1:0]       d_in,
  input  logic [E_W-1:0]       e_in,
  input  logic [F_W-1:0]       f_in,
  output logic [D_W-1:0]       snap_d,
  output logic [E_W+F_W-1:0]   snap_ef
);
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    // NOTE: the snapshot is an ordinary flop bank, not a RAM, so it takes the clear like any register.
    if (reset) begin
      snap_d  <= '0;
      snap_ef <= '0;
    end else if (capture) begin
      snap_d  <= d_in;
      snap_ef <= {e_in, f_in};
    end
  end
endmodule

module hier_bus_reader_chunk_sel #(
  parameter int D_W     = 900,
  parameter int CHUNK_W = 30,
  parameter int IDX_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture,
  input  logic                 advance,
  input  logic [IDX_W-1:0]     next_idx,
  input  logic [CHUNK_W-1:0]   d_first,
  input  logic [D_W-1:0]       snap_d,
  output logic [CHUNK_W-1:0]   out_data
);
  localparam int OFF_W = $clog2(D_W);

  logic [OFF_W-1:0]   offset;
  logic [CHUNK_W-1:0] next_chunk;

  assign offset = OFF_W'(next_idx) * OFF_W'(CHUNK_W);

  // Chunk 0 comes straight from d_in because the snapshot is being written on the same edge.
  always_comb begin
    // NOTE: default assignment first, so no path through this block can infer a latch.
    next_chunk = out_data;
    if (capture)      next_chunk = d_first;
    else if (advance) next_chunk = snap_d[offset +: CHUNK_W];
  end

  always_ff @(posedge clk) begin
    if (reset) out_data <= '0;
    else       out_data <= next_chunk;
  end
endmodule

module hier_bus_reader_ctrl #(
  parameter int D_W     = 900,
  parameter int CHUNK_W = 30,
  parameter int IDX_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 out_ready,
  input  logic [CHUNK_W-1:0]   out_data,
  output logic                 capture,
  output logic                 advance,
  output logic [IDX_W-1:0]     next_idx,
  output logic                 busy,
  output logic                 out_valid,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic [CHUNK_W-1:0]   checksum,
  output logic                 done
);
  typedef enum logic {IDLE, SEND} state_t;

  localparam int               N_CHUNKS = D_W / CHUNK_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

  state_t             state;
  logic [CHUNK_W-1:0] acc;

  assign capture  = (state == IDLE) && start;
  assign advance  = out_valid && out_ready && !out_last;
  assign next_idx = out_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      acc       <= '0;
      checksum  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SEND;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_last  <= (N_CHUNKS == 1);
            acc       <= '0;
          end
        end
        SEND: begin
          if (out_ready) begin
            acc <= acc ^ out_data;
            if (out_last) begin
              // Final transfer: publish the checksum and drop back so a start in the done cycle is taken.
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
              checksum  <= acc ^ out_data;
              done      <= 1'b1;
            end else begin
              out_idx  <= next_idx;
              out_last <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module hier_bus_reader #(
  parameter int D_W     = 900,
  parameter int CHUNK_W = 30,
  parameter int E_W     = 10,
  parameter int F_W     = 5,
  parameter int IDX_W   = 5
) (
  input  logic           clk,
  input  logic           reset,
  hier_bus_reader_if.slave bus
);
  logic [D_W-1:0]     snap_d;
  logic               capture;
  logic               advance;
  logic [IDX_W-1:0]   next_idx;
  logic [CHUNK_W-1:0] out_data;

  assign bus.out_data = out_data;

  hier_bus_reader_capture #(.D_W(D_W), .E_W(E_W), .F_W(F_W)) u_capture (
    .clk     (clk),
    .reset   (reset),
    .capture (capture),
    .d_in    (bus.d_in),
    .e_in    (bus.e_in),
    .f_in    (bus.f_in),
    .snap_d  (snap_d),
    .snap_ef (bus.snap_ef)
  );

  hier_bus_reader_chunk_sel #(.D_W(D_W), .CHUNK_W(CHUNK_W), .IDX_W(IDX_W)) u_chunk_sel (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .advance  (advance),
    .next_idx (next_idx),
    .d_first  (bus.d_in[CHUNK_W-1:0]),
    .snap_d   (snap_d),
    .out_data (out_data)
  );

  hier_bus_reader_ctrl #(.D_W(D_W), .CHUNK_W(CHUNK_W), .IDX_W(IDX_W)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .start     (bus.start),
    .out_ready (bus.out_ready),
    .out_data  (out_data),
    .capture   (capture),
    .advance   (advance),
    .next_idx  (next_idx),
    .busy      (bus.busy),
    .out_valid (bus.out_valid),
    .out_idx   (bus.out_idx),
    .out_last  (bus.out_last),
    .checksum  (bus.checksum),
    .done      (bus.done)
  );
endmodule

// File: doc/hier_bus_reader.md
# hier_bus_reader

Sequential consumer for the hierarchical floorplan test design: it snapshots the wide `d` bus (900 b) plus the `e` (10 b) and `f` (5 b) side buses driven by the mid-level blocks. It then reads the `d` snapshot out as 30-bit chunks over a valid/ready stream and reports an XOR checksum. It is built from three child instances, so the floorplanner sees a non-trivial hierarchy with registered state on both sides of the bus.

## Interface
Parameters:
- `D_W`, 900, width of the `d` bus; must be a multiple of `CHUNK_W`.
- `CHUNK_W`, 30, width of one output chunk.
- `E_W`, 10, width of the `e` bus.
- `F_W`, 5, width of the `f` bus.
- `IDX_W`, 5, chunk index width, ≥ clog2(`D_W`/`CHUNK_W`).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `d_in`  in  D_W  wide data bus to be read.
- `e_in`  in  E_W  side bus, captured with `d_in`.
- `f_in`  in  F_W  side bus, captured with `d_in`.
- `start`  in  1  request a snapshot and readout.
- `busy`  out  1  high from capture until readout completes.
- `out_valid`  out  1  chunk available.
- `out_ready`  in  1  downstream accepts chunk.
- `out_data`  out  CHUNK_W  current chunk.
- `out_idx`  out  IDX_W  index of current chunk, 0 = bits [29:0].
- `out_last`  out  1  current chunk is the final one.
- `snap_ef`  out  E_W+F_W  captured {e,f}, held until the next capture.
- `checksum`  out  CHUNK_W  XOR of all chunks sent; valid when `done` is asserted.
- `done`  out  1  one-cycle pulse after the last chunk transfers.

## Operation
- Child instances:
  - capture: snapshot registers for d, e and f.
  - chunk select: registered mux from the snapshot to `out_data`.
  - control: FSM, index counter and checksum accumulator.
- FSM states are IDLE and SEND.
- IDLE:
  - `start`=1 captures `d_in`, `e_in` and `f_in` into the snapshot.
  - Index is cleared to 0 and the checksum accumulator to 0.
  - Next state is SEND.
- SEND:
  - `out_valid`=1 and `out_data` = snap_d[idx*CHUNK_W +: CHUNK_W].
  - `out_last`=1 when idx = D_W/CHUNK_W−1.
- Transfer occurs on any cycle with `out_valid` && `out_ready`:
  - accumulator ^= `out_data`;
  - idx increments.
- On transfer of the last chunk:
  - next state is IDLE;
  - `done`=1 next cycle;
  - `checksum` takes the final accumulator value;
  - idx returns to 0, with no wrap past the last chunk.
- Backpressure: while `out_valid` && !`out_ready`, `out_data`, `out_idx` and `out_last` stay stable and the accumulator does not change.
- `start` is ignored while in SEND; the snapshot does not change during readout.
- `start` in the same cycle as the `done` pulse is accepted, because the FSM is already in IDLE.
- `d_in`, `e_in` and `f_in` are sampled only on the accepted-start cycle; changes at any other time have no effect.
- Reset, including mid-readout:
  - state IDLE, idx 0;
  - snapshot, `snap_ef` and `checksum` cleared to 0;
  - `busy`, `out_valid`, `out_last` and `done` = 0;
  - `out_data` and `out_idx` = 0;
  - a partial readout is abandoned, and no `done` is asserted for it.

## Timing
- Accepted `start` at cycle t gives `busy`=1 and `out_valid`=1 with chunk 0 at t+1.
- With `out_ready` held at 1:
  - chunk k is presented at t+1+k;
  - the last chunk (k=29) is at t+30;
  - `done`=1, `busy`=0 and `out_valid`=0 at t+31.
- Each cycle with `out_ready`=0 delays all later chunks and `done` by one cycle.
- `out_data` is registered; there is no combinational path from `out_ready` to `out_data`, and `out_valid` depends only on state.
- `snap_ef` updates at t+1 and then holds.
- `checksum` updates together with `done` and holds until reset. An accepted `start` clears the internal accumulator but does not change `checksum`.

## Test plan
- Reset, then `start` with d = chunk k holding value k (k = 0..29), and `out_ready`=1:
  - 30 chunks appear at t+1..t+30 with `out_data`=`out_idx`=k;
  - `out_last` only at k=29;
  - `done` at t+31 with `checksum`=1.
- d all-ones, e=10'h3FF, f=5'h15:
  - every chunk = 30'h3FFFFFFF;
  - `checksum`=0;
  - `snap_ef`=15'h7FF5.
- Backpressure: drop `out_ready` for 3 cycles at chunk 5 and randomly thereafter:
  - chunk 5 is held stable;
  - no chunk is skipped or duplicated;
  - `done` is delayed by exactly the number of stall cycles.
- `start` pulsed during SEND while `d_in` changes:
  - ignored;
  - all chunks match the original snapshot;
  - a single `done` pulse.
- `reset` asserted at chunk 12:
  - next cycle all outputs 0, FSM in IDLE, no `done`;
  - a new `start` begins again at chunk 0.
- `start` in the `done` cycle:
  - a new capture is accepted;
  - chunk 0 of the new data appears the next cycle.
